hazard_ctrl: RTL
================

# hazard_ctrl

- Pipeline sequencing controller for the 5-stage core.
- Decides each cycle whether PC, IF/ID, ID/EX and EX/MEM advance, hold, flush or take a bubble.
- Handles three cases: load-use hazards, taken-branch flushes resolved in ID, and a multi-cycle multiply occupying EX.
- Sits beside the pipeline registers and drives their write, flush and bubble controls; also keeps a stall-cycle counter.

## Interface
Parameters:
- MUL_LAT, 4, number of cycles a multiply occupies EX (legal range 1–16)

Ports:
- clk_i  in  1  clock, all state updates on rising edge
- rst_i  in  1  synchronous, active-low reset
- idex_memread_i  in  1  instruction now in EX is a load
- idex_rtaddr_i  in  5  destination rt of instruction in EX
- idex_mul_i  in  1  instruction now in EX is a multiply
- ifid_rsaddr_i  in  5  rs of instruction in ID
- ifid_rtaddr_i  in  5  rt of instruction in ID
- ifid_uses_rt_i  in  1  instruction in ID reads rt as a source
- branch_taken_i  in  1  branch in ID resolved taken this cycle
- pc_write_o  out  1  PC update enable
- ifid_write_o  out  1  IF/ID load enable
- ifid_flush_o  out  1  IF/ID loads a NOP
- idex_write_o  out  1  ID/EX load enable
- idex_bubble_o  out  1  ID/EX loads all-zero wb/mem/ex controls
- exmem_bubble_o  out  1  EX/MEM loads all-zero controls
- mul_busy_o  out  1  multiply stall in progress
- stall_cnt_o  out  16  count of cycles with pc_write_o=0, saturating

## Operation
- FSM states:
  - RUN: normal flow.
  - MUL: multiply draining. Down-counter cnt, width clog2(MUL_LAT)+1.
- Multiply, entered from RUN when idex_mul_i=1 and MUL_LAT≥2:
  - Assert mul stall this cycle.
  - Load cnt=MUL_LAT-2; next state MUL.
- In MUL:
  - cnt≠0: assert mul stall, decrement cnt.
  - cnt=0: no mul stall; next state RUN.
  - idex_mul_i is ignored in MUL.
- MUL_LAT=1: a multiply never stalls; the FSM stays in RUN.
- Mul stall drives: pc_write_o=0, ifid_write_o=0, idex_write_o=0, exmem_bubble_o=1, mul_busy_o=1.
- Load-use detection, evaluated only when no mul stall is active:
  - Condition: idex_memread_i=1, idex_rtaddr_i≠0, and either idex_rtaddr_i==ifid_rsaddr_i, or ifid_uses_rt_i=1 with idex_rtaddr_i==ifid_rtaddr_i.
  - Outputs: pc_write_o=0, ifid_write_o=0, idex_write_o=1, idex_bubble_o=1.
- Branch flush:
  - ifid_flush_o = branch_taken_i only when neither a mul stall nor a load-use stall is active.
  - While ID is held, the flush is suppressed and the branch is re-evaluated next cycle.
- Priority: mul stall > load-use > branch flush > normal.
- Normal flow: all write enables 1, all flush and bubble outputs 0.
- stall_cnt_o:
  - Increments on each clock edge where pc_write_o=0 and rst_i=1.
  - Holds at 16'hFFFF once reached.

## Timing
- All outputs are combinational from the current inputs and registered state. No added latency.
- Reset:
  - While rst_i=0: pc_write_o, ifid_write_o, idex_write_o = 1; all other 1-bit outputs = 0.
  - At the edge with rst_i=0: state←RUN, cnt←0, stall_cnt_o←0.
  - Reset mid-multiply aborts it. The first cycle after reset is RUN.
- Multiply timing:
  - EX occupancy is exactly MUL_LAT cycles.
  - The mul stall lasts MUL_LAT-1 consecutive cycles.
  - On the release cycle ID/EX loads the next instruction, and EX/MEM captures the multiply result.
- Back-to-back multiplies:
  - The second multiply enters EX the cycle after release.
  - It is detected in RUN and stalls again for MUL_LAT-1 cycles.
- Load-use stall: exactly 1 cycle per hazard, because the bubble clears idex_memread_i on the next cycle.
- Loads to $0 never stall.

## Test plan
- Load-use via rs:
  - Stimulus: idex_memread_i=1, idex_rtaddr_i=5, ifid_rsaddr_i=5 for one cycle.
  - Response: pc_write_o=0, ifid_write_o=0, idex_bubble_o=1 for 1 cycle; stall_cnt_o 0→1.
- Load-use via rt and $0:
  - Stimulus A: rt match with ifid_uses_rt_i=0. Response: no stall.
  - Stimulus B: rt match with ifid_uses_rt_i=1. Response: 1-cycle stall.
  - Stimulus C: idex_rtaddr_i=0 with any match. Response: no stall.
- Multiply, MUL_LAT=4:
  - Stimulus: idex_mul_i=1 held high.
  - Response: mul_busy_o=1 and exmem_bubble_o=1 for exactly 3 cycles, released on the 4th; stall_cnt_o +3.
  - Repeat with MUL_LAT=1. Response: no stall.
- Branch vs stall priority:
  - Stimulus: branch_taken_i=1 together with a load-use hazard.
  - Response: ifid_flush_o=0 in the stall cycle and 1 in the following cycle.
  - Stimulus: branch_taken_i=1 during a mul stall. Response: ifid_flush_o=0.
- Reset mid-multiply:
  - Stimulus: drop rst_i on the 2nd mul-stall cycle.
  - Response: outputs show enables=1, others 0; stall_cnt_o=0 after the edge; RUN on the next cycle.
- Saturation:
  - Stimulus: preload by holding stalls for 65,540 cycles (repeated load-use).
  - Response: stall_cnt_o stays at 16'hFFFF.

Source files
------------

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline sequencing controller for the 5-stage core.
// Each cycle it decides whether PC, IF/ID, ID/EX and EX/MEM advance, hold,
// flush or take a bubble. It covers three cases: load-use hazards, taken
// branches resolved in ID, and a multi-cycle multiply occupying EX. It also
// counts the cycles in which the PC is held.
module hazard_ctrl #(
  parameter int MUL_LAT = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        idex_memread_i,
  input  logic [4:0]  idex_rtaddr_i,
  input  logic        idex_mul_i,
  input  logic [4:0]  ifid_rsaddr_i,
  input  logic [4:0]  ifid_rtaddr_i,
  input  logic        ifid_uses_rt_i,
  input  logic        branch_taken_i,
  output logic        pc_write_o,
  output logic        ifid_write_o,
  output logic        ifid_flush_o,
  output logic        idex_write_o,
  output logic        idex_bubble_o,
  output logic        exmem_bubble_o,
  output logic        mul_busy_o,
  output logic [15:0] stall_cnt_o
);

  localparam int CNT_W = $clog2(MUL_LAT) + 1;
  // The first stall cycle happens in RUN, so the counter only needs to cover
  // the remaining MUL_LAT-2 stall cycles before the release cycle.
  localparam logic [CNT_W-1:0] CNT_LOAD = (MUL_LAT >= 2) ? CNT_W'(MUL_LAT - 2) : '0;
  localparam logic MUL_STALLS = (MUL_LAT >= 2);

  typedef enum logic {
    ST_RUN = 1'b0,
    ST_MUL = 1'b1
  } state_t;

  state_t            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [15:0]       stall_cnt_q;
  logic [15:0]       stall_cnt_d;

  logic mul_start;
  logic mul_stall;
  logic load_use;

  // A multiply is only recognised from RUN; in MUL the EX instruction is
  // still the one already being drained, so idex_mul_i is ignored there.
  assign mul_start = (state_q == ST_RUN) && idex_mul_i && MUL_STALLS;
  assign mul_stall = mul_start || ((state_q == ST_MUL) && (cnt_q != '0));

  // Load-use hazard; a load into $0 can never create a real dependency.
  assign load_use = !mul_stall && idex_memread_i && (idex_rtaddr_i != 5'd0) &&
                    ((idex_rtaddr_i == ifid_rsaddr_i) ||
                     (ifid_uses_rt_i && (idex_rtaddr_i == ifid_rtaddr_i)));

  // Multiply FSM: enter MUL with the remaining stall count, release at zero.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (mul_start) begin
            state_q <= ST_MUL;
            cnt_q   <= CNT_LOAD;
          end
        end
        ST_MUL: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
          end else begin
            state_q <= ST_RUN;
          end
        end
      endcase
    end
  end

  // Pipeline register controls, priority mul stall > load-use > branch flush.
  always_comb begin
    pc_write_o     = 1'b1;
    ifid_write_o   = 1'b1;
    ifid_flush_o   = 1'b0;
    idex_write_o   = 1'b1;
    idex_bubble_o  = 1'b0;
    exmem_bubble_o = 1'b0;
    mul_busy_o     = 1'b0;
    if (rst_i) begin
      if (mul_stall) begin
        pc_write_o     = 1'b0;
        ifid_write_o   = 1'b0;
        idex_write_o   = 1'b0;
        exmem_bubble_o = 1'b1;
        mul_busy_o     = 1'b1;
      end else if (load_use) begin
        pc_write_o    = 1'b0;
        ifid_write_o  = 1'b0;
        idex_bubble_o = 1'b1;
      end else begin
        // A branch held in ID is simply re-evaluated once ID moves again.
        ifid_flush_o = branch_taken_i;
      end
    end
  end

  // Saturating count of cycles in which the PC was held.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!pc_write_o && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  // Stall counter register.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      stall_cnt_q <= 16'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;

endmodule
